// File: rtl/alu_issue_ctrl.sv
// rtl/alu_issue_ctrl.sv - serialising issue controller and 8-entry register file for a registered ALU
//
// Accepts one instruction at a time on instr_valid/instr_ready, drives the
// registered ALU inputs for one EXEC cycle, writes the ALU result back to
// reg[rd] at the end of WB, and rejects the reserved opcode with an err pulse.
//
// Ports:
//   clk, rst_n                     clock, asynchronous active-low reset
//   instr_valid/instr_ready        instruction handshake
//   instr_op/rd/rs/rt/cin/imm      instruction fields
//   alu_a/alu_b/alu_c_in/alu_op    registered ALU operand and opcode drive
//   alu_out/alu_c_out              registered ALU result and carry
//   done, err                      one-cycle writeback / reject pulses
//   cflag                          carry of the last ADD/SUB
//   dbg_addr/dbg_data              combinational register file read port
module alu_issue_ctrl #(
    parameter int N = 32
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         instr_valid,
    output logic         instr_ready,
    input  logic [2:0]   instr_op,
    input  logic [2:0]   instr_rd,
    input  logic [2:0]   instr_rs,
    input  logic [2:0]   instr_rt,
    input  logic         instr_cin,
    input  logic [N-1:0] instr_imm,
    output logic [N-1:0] alu_a,
    output logic [N-1:0] alu_b,
    output logic         alu_c_in,
    output logic [2:0]   alu_op,
    input  logic [N-1:0] alu_out,
    input  logic         alu_c_out,
    output logic         done,
    output logic         err,
    output logic         cflag,
    input  logic [2:0]   dbg_addr,
    output logic [N-1:0] dbg_data
);

    localparam logic [2:0] OP_MOV   = 3'b000;
    localparam logic [2:0] OP_ADD   = 3'b010;
    localparam logic [2:0] OP_SUB   = 3'b011;
    localparam logic [2:0] OP_LOADI = 3'b110;
    localparam logic [2:0] OP_RSVD  = 3'b111;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_EXEC = 2'd1,
        S_WB   = 2'd2,
        S_ERR  = 2'd3
    } state_t;

    state_t         state_q, state_d;
    logic [2:0]     op_q;
    logic [2:0]     rd_q;
    logic [N-1:0]   alu_a_q, alu_b_q;
    logic           alu_c_in_q;
    logic [2:0]     alu_op_q;
    logic           cflag_q;
    logic [N-1:0]   regs_q [8];

    logic           accept;
    logic           issue;
    logic           is_arith;

    assign accept   = instr_valid && instr_ready;
    assign issue    = accept && (instr_op != OP_RSVD);
    assign is_arith = (instr_op == OP_ADD) || (instr_op == OP_SUB);

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    state_d = (instr_op == OP_RSVD) ? S_ERR : S_EXEC;
                end
            end
            S_EXEC:  state_d = S_WB;
            S_WB:    state_d = S_IDLE;
            S_ERR:   state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Output logic; ready is gated by rst_n so it reads 0 while reset is held
    always_comb begin
        instr_ready = rst_n && (state_q == S_IDLE);
        done        = (state_q == S_WB);
        err         = (state_q == S_ERR);
    end

    // Datapath. Operands are read from the register file at the accept edge so
    // the ALU inputs are already stable throughout EXEC; those operand
    // registers double as the instruction latch for rs/rt/cin/imm, so only op
    // and rd need to be kept separately for writeback.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_q       <= '0;
            rd_q       <= '0;
            alu_a_q    <= '0;
            alu_b_q    <= '0;
            alu_c_in_q <= 1'b0;
            alu_op_q   <= OP_MOV;
            cflag_q    <= 1'b0;
            for (int i = 0; i < 8; i++) begin
                regs_q[i] <= '0;
            end
        end else begin
            if (issue) begin
                op_q       <= instr_op;
                rd_q       <= instr_rd;
                alu_a_q    <= (instr_op == OP_LOADI) ? instr_imm : regs_q[instr_rs];
                alu_b_q    <= regs_q[instr_rt];
                alu_c_in_q <= is_arith && instr_cin;
                // LOADI passes the immediate straight through the ALU as a MOV
                alu_op_q   <= (instr_op == OP_LOADI) ? OP_MOV : instr_op;
            end
            if (state_q == S_WB) begin
                regs_q[rd_q] <= alu_out;
                if ((op_q == OP_ADD) || (op_q == OP_SUB)) begin
                    cflag_q <= alu_c_out;
                end
            end
        end
    end

    assign alu_a    = alu_a_q;
    assign alu_b    = alu_b_q;
    assign alu_c_in = alu_c_in_q;
    assign alu_op   = alu_op_q;
    assign cflag    = cflag_q;
    assign dbg_data = regs_q[dbg_addr];

endmodule
